// File: rtl/arb_pkg.sv
// Shared types and width helper for the request arbiter.
package arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam int MAX_REQ = 16;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational winner select: rotating scan after ptr, or lowest index first.
module rr_pick import arb_pkg::*; #(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  excl,
  input  logic          rr,
  output logic          vld,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] c;

  always_comb begin
    vld = 1'b0;
    idx = '0;
    c   = '0;
    for (int i = 0; i < N; i++) begin
      c = rr ? IW'((int'(ptr) + 1 + i) % N) : IW'(i);
      if (!vld && req[c] && !excl[c]) begin
        vld = 1'b1;
        idx = c;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority arbiter with per-owner hold limit; outputs decode registered state only.
module rr_arbiter import arb_pkg::*; #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int RR       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  output logic [N-1:0]          gnt,
  output logic [idx_w(N)-1:0]   gnt_id,
  output logic                  busy
);

  localparam int IW = idx_w(N);
  localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int HL = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HL);

  state_t        state;
  logic [IW-1:0] owner, ptr, pk_idx;
  logic [HW-1:0] hold;
  logic [N-1:0]  own_oh;
  logic          pk_vld, timeout, rel;

  assign own_oh  = N'(1) << owner;
  assign timeout = (MAX_HOLD != 0) && (hold == HOLD_LAST);
  assign rel     = !req[owner] || timeout;

  // Excluding the owner while granted lets a timeout hand off even in fixed mode.
  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .excl ((state == GRANT) ? own_oh : '0),
    .rr   (RR != 0),
    .vld  (pk_vld),
    .idx  (pk_idx)
  );

  assign busy   = (state == GRANT);
  assign gnt    = busy ? own_oh : '0;
  assign gnt_id = busy ? owner : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= '0;
      hold  <= '0;
      ptr   <= IW'(N - 1);
    end else begin
      case (state)
        IDLE: if (pk_vld) begin
          state <= GRANT;
          owner <= pk_idx;
          ptr   <= pk_idx;
          hold  <= '0;
        end
        GRANT: if (rel) begin
          hold <= '0;
          if (pk_vld) begin
            owner <= pk_idx;
            ptr   <= pk_idx;
          end else if (req[owner]) begin
            ptr <= owner;          // sole requester after timeout: re-grant in place
          end else begin
            state <= IDLE;
          end
        end else if (MAX_HOLD != 0 && hold != HOLD_LAST) begin
          hold <= hold + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench: expected grants queued at drive time, popped and checked after each edge.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] req_a, req_b;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] id_a, id_b;
  logic       busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [3:0] g;
    int         h;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  rr_arbiter #(.N(4), .MAX_HOLD(4), .RR(1)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .gnt(gnt_a), .gnt_id(id_a), .busy(busy_a)
  );

  rr_arbiter #(.N(4), .MAX_HOLD(0), .RR(0)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .gnt(gnt_b), .gnt_id(id_b), .busy(busy_b)
  );

  function automatic logic [1:0] id_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check(input bit sel);
    exp_t e;
    e = q.pop_front();
    chk({e.tag, ".gnt"},    sel ? 32'(gnt_b)  : 32'(gnt_a),  32'(e.g));
    chk({e.tag, ".gnt_id"}, sel ? 32'(id_b)   : 32'(id_a),   32'(id_of(e.g)));
    chk({e.tag, ".busy"},   sel ? 32'(busy_b) : 32'(busy_a), 32'(|e.g));
    if (e.h >= 0)
      chk({e.tag, ".hold"}, sel ? 32'(dut_b.hold) : 32'(dut_a.hold), 32'(e.h));
  endtask

  task automatic step(input bit sel, input logic [3:0] r, input logic [3:0] eg,
                      input int eh, input string tag);
    @(negedge clk);
    if (sel) req_b = r; else req_a = r;
    q.push_back('{tag, eg, eh});
    @(posedge clk);
    #1;
    check(sel);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    req_a = 4'b1111; req_b = 4'b0000;

    for (int i = 0; i < 3; i++) step(0, 4'b1111, 4'b0000, 0, "reset");

    // rotation: each owner holds 4 cycles, then hands off without a gap
    rst_a = 1'b1;
    for (int i = 0; i < 17; i++)
      step(0, 4'b1111, 4'(1 << ((i / 4) % 4)), i % 4, $sformatf("rot%0d", i));

    step(0, 4'b0100, 4'b0100, 0, "handoff");
    step(0, 4'b0000, 4'b0000, 0, "handoff_idle");
    step(0, 4'b0000, 4'b0000, 0, "idle");

    step(0, 4'b0010, 4'b0010, 0, "latency");
    step(0, 4'b0000, 4'b0000, 0, "latency_idle");

    for (int i = 0; i < 12; i++)
      step(0, 4'b0001, 4'b0001, i % 4, $sformatf("sole%0d", i));
    step(0, 4'b0000, 4'b0000, 0, "sole_idle");

    // a waiting requester never preempts; it wins only at the hold limit
    step(0, 4'b0001, 4'b0001, 0, "nopre0");
    step(0, 4'b0011, 4'b0001, 1, "nopre1");
    step(0, 4'b0011, 4'b0001, 2, "nopre2");
    step(0, 4'b0011, 4'b0001, 3, "nopre3");
    step(0, 4'b0011, 4'b0010, 0, "nopre_to");
    step(0, 4'b0000, 4'b0000, 0, "nopre_idle");

    // fixed priority, unlimited hold, reset mid-grant
    rst_b = 1'b1;
    for (int i = 0; i < 6; i++) step(1, 4'b1111, 4'b0001, 0, $sformatf("fix%0d", i));
    @(negedge clk);
    rst_b = 1'b0;
    q.push_back('{"rst_mid", 4'b0000, 0});
    #1;
    check(1);
    step(1, 4'b1111, 4'b0000, 0, "rst_held");
    rst_b = 1'b1;
    step(1, 4'b1111, 4'b0001, 0, "rst_release");
    step(1, 4'b1110, 4'b0010, 0, "fix_next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
